vga_pixel_streamer: RTL and testbench
=====================================

VGA_PIXEL_STREAMER -- requirements
Module: vga_pixel_streamer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, asserted level of hsync/vsync.
REQ-006 clock  input  1  pixel clock; all logic on posedge.
REQ-007 neg_reset  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  permits pixel consumption; timing runs regardless.
REQ-009 pix_valid  input  1  upstream word valid.
REQ-010 pix_data  input  24  upstream pixel, {R[7:0],G[7:0],B[7:0]}.
REQ-011 pix_sof  input  1  qualifies pix_data as first pixel of a frame.
REQ-012 clr_status  input  1  clears sticky status flags.
REQ-013 pix_ready  output  1  word consumed when pix_valid & pix_ready.
REQ-014 RED, GREEN, BLUE  output  8 each  pixel to the display stage.
REQ-015 video_on  output  1  high when outputs lie in visible region.
REQ-016 hsync, vsync  output  1 each  sync pulses, level SYNC_POL when asserted.
REQ-017 underflow, sof_error  output  1 each  sticky status flags.

Function
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) every clock, wrapping to 0; v_cnt SHALL increment on h wrap, wrapping 0 after V_TOTAL-1.
REQ-019 Visible region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync likewise on v_cnt.
REQ-020 RGB, video_on, hsync, vsync SHALL be registered with exactly 1 clock latency from counter state, all mutually aligned.
REQ-021 RGB SHALL be 0 whenever video_on is low or state is not RUN.
REQ-022 State machine: IDLE, SEEK, WAIT_FRAME, RUN.
REQ-023 IDLE: pix_ready=0; enable=1 -> SEEK next clock.
REQ-024 SEEK: pix_ready=1 and words discarded while pix_sof=0; pix_valid&pix_sof seen -> pix_ready drops combinationally, word not consumed, -> WAIT_FRAME.
REQ-025 WAIT_FRAME: pix_ready=0 until h_cnt=0 and v_cnt=0, then -> RUN in that same cycle (sof word consumed at (0,0)).
REQ-026 RUN: pix_ready = visible region; each visible clock consumes one word and drives it to RGB.
REQ-027 RUN underflow (visible, pix_valid=0): set underflow, output black, -> SEEK.
REQ-028 RUN misaligned sof (pix_valid&pix_sof at position other than (0,0)): set sof_error, do not consume, -> WAIT_FRAME.
REQ-029 enable=0 in any state SHALL -> IDLE next clock; pixels in flight discarded, output black from next visible clock.
REQ-030 clr_status=1 SHALL clear both flags; simultaneous set and clear: set wins.
REQ-031 Counters SHALL be 10 bits minimum, sized by clog2 of totals.

Reset
REQ-032 neg_reset low SHALL immediately force h_cnt=v_cnt=0, state IDLE, RGB=0, video_on=0, pix_ready=0, hsync=vsync=~SYNC_POL, flags=0.
REQ-033 Reset mid-frame SHALL abandon the frame; after release, timing restarts at (0,0) and resync proceeds via SEEK.

Verification
REQ-034 Default params, enable=0: hsync period 800 clocks, low 96 clocks starting h=656; vsync low lines 490-491; frame 420000 clocks; video_on high 640 clocks/line.
REQ-035 enable=1, upstream always valid, sof on word 0, data = pixel index: first visible output RGB=0x000000 one clock after (0,0); pixel (5,0) = 0x000005.
REQ-036 Garbage words before sof: discarded in SEEK; first visible pixel equals sof word; no flags set.
REQ-037 pix_valid dropped at (100,10): underflow=1, rest of frame black, display resumes at next frame's sof.
REQ-038 sof asserted at (300,2): sof_error=1, black until next frame, sof word displayed at (0,0).
REQ-039 neg_reset pulsed low at (400,200): outputs zero asynchronously; after release hsync first asserts 656 clocks later.

Source files
------------

// File: rtl/vga_pixel_streamer.sv
// VGA timing generator that streams upstream pixels into the visible window.
// Upstream frames are locked to the raster: the sof word is shown at (0,0),
// and any loss of alignment drops back to resynchronisation with a sticky flag.
module vga_pixel_streamer #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        clock,
   input  logic        neg_reset,
   input  logic        enable,
   input  logic        pix_valid,
   input  logic [23:0] pix_data,
   input  logic        pix_sof,
   input  logic        clr_status,
   output logic        pix_ready,
   output logic [7:0]  RED,
   output logic [7:0]  GREEN,
   output logic [7:0]  BLUE,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        underflow,
   output logic        sof_error
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
   localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
   localparam logic SYNC_ON = (SYNC_POL != 0);

   typedef enum logic [1:0] {IDLE, SEEK, WAIT_FRAME, RUN} state_t;

   state_t         state, state_nxt;
   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic           visible, origin, h_sync_on, v_sync_on, live;
   logic           consume, set_uf, set_se;

   assign visible   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign origin    = (h_cnt == '0) && (v_cnt == '0);
   assign h_sync_on = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign v_sync_on = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
   // A waiting frame goes live at the origin, so the sof word is consumed there.
   assign live      = (state == RUN) || ((state == WAIT_FRAME) && origin);

   // Raster counters free-run independent of enable.
   always_ff @(posedge clock or negedge neg_reset) begin
      if (!neg_reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge neg_reset) begin
      if (!neg_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next state, handshake and status events.
   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      consume   = 1'b0;
      set_uf    = 1'b0;
      set_se    = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = SEEK;
            SEEK: begin
               // Hold the sof word back; it is shown at the next origin.
               if (pix_valid && pix_sof) state_nxt = WAIT_FRAME;
               else                      pix_ready = 1'b1;
            end
            WAIT_FRAME, RUN: begin
               if (live) begin
                  state_nxt = RUN;
                  if (visible) begin
                     if (!pix_valid) begin
                        pix_ready = 1'b1;
                        set_uf    = 1'b1;
                        state_nxt = SEEK;
                     end else if (pix_sof && !origin) begin
                        set_se    = 1'b1;
                        state_nxt = WAIT_FRAME;
                     end else begin
                        pix_ready = 1'b1;
                        consume   = 1'b1;
                     end
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Display outputs: one clock behind the counters, all aligned.
   always_ff @(posedge clock or negedge neg_reset) begin
      if (!neg_reset) begin
         {RED, GREEN, BLUE} <= '0;
         video_on <= 1'b0;
         hsync    <= ~SYNC_ON;
         vsync    <= ~SYNC_ON;
      end else begin
         {RED, GREEN, BLUE} <= consume ? pix_data : 24'd0;
         video_on <= visible;
         hsync    <= h_sync_on ? SYNC_ON : ~SYNC_ON;
         vsync    <= v_sync_on ? SYNC_ON : ~SYNC_ON;
      end
   end

   // Sticky flags; a new event beats a simultaneous clear.
   always_ff @(posedge clock or negedge neg_reset) begin
      if (!neg_reset) begin
         underflow <= 1'b0;
         sof_error <= 1'b0;
      end else begin
         underflow <= set_uf | (underflow & ~clr_status);
         sof_error <= set_se | (sof_error & ~clr_status);
      end
   end

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Randomized bench for vga_pixel_streamer on a shrunken raster, with a
// position-arithmetic reference model and an upstream frame queue.
module tb_vga_pixel_streamer;

   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FR = HT * VT;
   localparam logic POL = 1'b0;

   logic        clock = 1'b0, neg_reset = 1'b1, enable = 1'b0;
   logic        pix_valid = 1'b0, pix_sof = 1'b0, clr_status = 1'b0;
   logic [23:0] pix_data = '0;
   logic        pix_ready, video_on, hsync, vsync, underflow, sof_error;
   logic [7:0]  RED, GREEN, BLUE;

   always #5 clock = ~clock;

   vga_pixel_streamer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
   ) dut (
      .clock(clock), .neg_reset(neg_reset), .enable(enable),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
      .clr_status(clr_status), .pix_ready(pix_ready),
      .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .video_on(video_on),
      .hsync(hsync), .vsync(vsync), .underflow(underflow), .sof_error(sof_error)
   );

   typedef struct packed {logic sof; logic [23:0] d;} word_t;
   word_t q[$];

   int n_chk = 0, n_pass = 0;
   int unsigned drop_pm = 0, trunc_pm = 0, clr_pm = 0, garb_max = 3;
   int shown_cnt = 0, uf_cnt = 0, se_cnt = 0;
   logic en_cur = 1'b0;

   // Reference state: t = clocks since reset release, mode 0 idle/1 seek/2 wait/3 run.
   int t = 0, mode = 0;
   logic [23:0] e_rgb = '0;
   logic e_vid = 1'b0, e_hs = ~POL, e_vs = ~POL, e_uf = 1'b0, e_se = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic chk_outputs(input string pfx);
      chk({pfx, "rgb"},       32'({RED, GREEN, BLUE}), 32'(e_rgb));
      chk({pfx, "video_on"},  32'(video_on),  32'(e_vid));
      chk({pfx, "hsync"},     32'(hsync),     32'(e_hs));
      chk({pfx, "vsync"},     32'(vsync),     32'(e_vs));
      chk({pfx, "underflow"}, 32'(underflow), 32'(e_uf));
      chk({pfx, "sof_error"}, 32'(sof_error), 32'(e_se));
   endtask

   // Upstream source: optional garbage, then one frame of index-valued pixels
   // (occasionally cut short so the next sof lands mid-frame).
   task automatic refill();
      int len;
      if (q.size() != 0) return;
      for (int i = 0; i < int'($urandom_range(garb_max)); i++)
         q.push_back({1'b0, 24'h800000 | 24'($urandom)});
      len = HA * VA;
      if ($urandom_range(999) < trunc_pm) len = $urandom_range(HA * VA - 1, 1);
      for (int i = 0; i < len; i++) q.push_back({(i == 0), 24'(i)});
   endtask

   task automatic cycle();
      int h, v, nmode;
      logic vis, org, rdy, shown, uf, se;
      chk_outputs("");
      refill();
      enable     = en_cur;
      pix_valid  = ($urandom_range(999) >= drop_pm);
      pix_sof    = pix_valid ? q[0].sof : ($urandom_range(1) == 1);
      pix_data   = pix_valid ? q[0].d : 24'($urandom);
      clr_status = ($urandom_range(999) < clr_pm);
      #1;
      h = t % HT;
      v = (t / HT) % VT;
      vis = (h < HA) && (v < VA);
      org = (h == 0) && (v == 0);
      rdy = 1'b0; shown = 1'b0; uf = 1'b0; se = 1'b0; nmode = mode;
      if (!enable) nmode = 0;
      else if (mode == 0) nmode = 1;
      else if (mode == 1) begin
         if (pix_valid && pix_sof) nmode = 2;
         else rdy = 1'b1;
      end else if (mode == 3 || org) begin
         nmode = 3;
         if (vis) begin
            if (!pix_valid) begin rdy = 1'b1; uf = 1'b1; nmode = 1; end
            else if (pix_sof && !org) begin se = 1'b1; nmode = 2; end
            else begin rdy = 1'b1; shown = 1'b1; end
         end
      end
      chk("pix_ready", 32'(pix_ready), 32'(rdy));
      @(posedge clock);
      if (pix_valid && rdy) void'(q.pop_front());
      if (shown) shown_cnt++;
      if (uf) uf_cnt++;
      if (se) se_cnt++;
      e_rgb = shown ? pix_data : 24'd0;
      e_vid = vis;
      e_hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
      e_vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
      e_uf  = uf | (e_uf & ~clr_status);
      e_se  = se | (e_se & ~clr_status);
      mode  = nmode;
      t++;
      @(negedge clock);
   endtask

   task automatic model_reset();
      t = 0; mode = 0; e_rgb = '0; e_vid = 1'b0;
      e_hs = ~POL; e_vs = ~POL; e_uf = 1'b0; e_se = 1'b0;
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic do_reset();
      #2 neg_reset = 1'b0;
      #1;
      model_reset();
      chk_outputs("rst_");
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      repeat (2) @(negedge clock);
      neg_reset = 1'b1;
   endtask

   initial begin
      model_reset();
      #1 neg_reset = 1'b0;
      #2;
      chk_outputs("por_");
      chk("por_pix_ready", 32'(pix_ready), 32'd0);
      @(negedge clock);
      neg_reset = 1'b1;

      // Timing only, display disabled.
      repeat (2 * FR + 17) cycle();

      // Clean streaming; the first frame in the queue carries leading garbage.
      en_cur = 1'b1;
      repeat (FR) cycle();
      garb_max = 0;
      repeat (3 * FR) cycle();
      chk("displayed_pixels", 32'(shown_cnt > 3 * HA * VA), 32'd1);
      chk("clean_underflow", 32'(uf_cnt), 32'd0);

      // Random valid drops with occasional status clears.
      drop_pm = 3; clr_pm = 20;
      repeat (8 * FR) cycle();

      // Truncated frames and garbage: misaligned sof.
      drop_pm = 0; trunc_pm = 150; garb_max = 2;
      repeat (8 * FR) cycle();
      trunc_pm = 0; garb_max = 0;

      // Enable toggling.
      for (int k = 0; k < 6; k++) begin
         en_cur = 1'b0;
         repeat ($urandom_range(30, 1)) cycle();
         en_cur = 1'b1;
         repeat (2 * FR) cycle();
      end

      // Reset mid-frame, then resync.
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(2 * FR, FR)) cycle();
         do_reset();
         repeat (2 * FR) cycle();
      end
      chk("saw_underflow", 32'(uf_cnt > 0), 32'd1);
      chk("saw_sof_error", 32'(se_cnt > 0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
